// File: rtl/dadda_mult_rr_scheduler.sv
// Round-robin front end that time-shares one unsigned 8x8 multiplier between
// NUM_REQ requesters; operands registered before the multiplier, product after.

module eight_bit_accurate_dadda_multiplier (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] p
);

   // Exact partial-product reduction; synthesis folds the sum into a compressor tree.
   always_comb begin
      p = '0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p + ({8'b0, a} << i);
      end
   end

endmodule

// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation in flight; grant window open
// CALC  | operands captured; product is registered on the next edge
// RESP  | res_valid held until res_ready; window open when res_ready=1
module dadda_mult_rr_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [8*NUM_REQ-1:0] req_in1,
   input  logic [8*NUM_REQ-1:0] req_in2,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [15:0]          res_out,
   output logic [ID_W-1:0]      res_id,
   output logic                 busy,
   output logic [15:0]          op_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t          state;
   logic [7:0]      op1;
   logic [7:0]      op2;
   logic [ID_W-1:0] owner;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] gnt_idx;
   logic [ID_W-1:0] rr_nxt;
   logic            gnt_any;
   logic            gnt_win;
   logic            grant;
   logic [7:0]      sel1;
   logic [7:0]      sel2;
   logic [15:0]     prod;

   // Scan from rr_ptr upward, wrapping at NUM_REQ; first valid requester wins.
   always_comb begin
      int idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_any && req_valid[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = ID_W'(idx);
         end
      end
   end

   assign gnt_win   = (state == ST_IDLE) || ((state == ST_RESP) && res_ready);
   assign grant     = gnt_win && gnt_any;
   assign req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
   assign sel1      = req_in1[8*gnt_idx +: 8];
   assign sel2      = req_in2[8*gnt_idx +: 8];
   assign rr_nxt    = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

   eight_bit_accurate_dadda_multiplier u_mult (
      .a (op1),
      .b (op2),
      .p (prod)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op1       <= '0;
         op2       <= '0;
         owner     <= '0;
         rr_ptr    <= '0;
         res_valid <= 1'b0;
         res_out   <= '0;
         res_id    <= '0;
         busy      <= 1'b0;
         op_count  <= '0;
      end else begin
         if (grant) begin
            op1    <= sel1;
            op2    <= sel2;
            owner  <= gnt_idx;
            rr_ptr <= rr_nxt;
         end
         case (state)
            ST_IDLE: begin
               if (grant) state <= ST_CALC;
               busy <= grant;
            end
            ST_CALC: begin
               res_out   <= prod;
               res_id    <= owner;
               res_valid <= 1'b1;
               state     <= ST_RESP;
               busy      <= 1'b1;
            end
            ST_RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  op_count  <= op_count + 16'd1;
                  state     <= grant ? ST_CALC : ST_IDLE;
                  busy      <= grant;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dadda_mult_rr_scheduler.sv
// Directed and randomized checks for the shared-multiplier round-robin scheduler.

module tb_dadda_mult_rr_scheduler;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                 clk;
   logic                 rst;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [8*NUM_REQ-1:0] req_in1;
   logic [8*NUM_REQ-1:0] req_in2;
   logic                 res_valid;
   logic                 res_ready;
   logic [15:0]          res_out;
   logic [ID_W-1:0]      res_id;
   logic                 busy;
   logic [15:0]          op_count;

   dadda_mult_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_out   (res_out),
      .res_id    (res_id),
      .busy      (busy),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] p;
   } vec_t;

   vec_t        vecs[6];
   int          total;
   int          bad;
   logic [15:0] exp_cnt;

   // random-phase scoreboard
   logic            pend;
   logic [15:0]     exp_p;
   logic [ID_W-1:0] exp_id;
   int              nx;
   int              wt[NUM_REQ];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
      req_in1[8*i +: 8] = a;
      req_in2[8*i +: 8] = b;
   endtask

   task automatic observe_result();
      if (res_valid && res_ready) begin
         check("rnd_have_exp", 32'(pend), 32'd1);
         check("rnd_prod", 32'(res_out), 32'(exp_p));
         check("rnd_id", 32'(res_id), 32'(exp_id));
         pend = 1'b0;
         nx++;
      end
   endtask

   task automatic run_one(input vec_t v);
      bit got;
      got       = 1'b0;
      res_ready = 1'b1;
      req_valid = '0;
      req_valid[v.id] = 1'b1;
      set_ops(v.id, v.a, v.b);
      for (int c = 0; c < 10 && !got; c++) begin
         @(negedge clk);
         if (req_ready != 0) got = 1'b1;
         else tick();
      end
      check("vec_grant", 32'(req_ready), 32'(1 << v.id));
      tick();
      req_valid = '0;
      @(negedge clk);
      check("vec_calc_novalid", 32'(res_valid), 32'd0);
      tick();
      @(negedge clk);
      check("vec_valid", 32'(res_valid), 32'd1);
      check("vec_prod", 32'(res_out), 32'(v.p));
      check("vec_id", 32'(res_id), 32'(v.id));
      tick();
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      check("vec_drop", 32'(res_valid), 32'd0);
      check("vec_hold_out", 32'(res_out), 32'(v.p));
      check("vec_opcount", 32'(op_count), 32'(exp_cnt));
      tick();
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      res_ready = 1'b0;
      tick();
      tick();
      rst     = 1'b0;
      exp_cnt = '0;
   endtask

   initial begin
      int ngr, nres, last, gid;
      logic [NUM_REQ-1:0] gmask;
      bool_dummy: begin end
      total   = 0;
      bad     = 0;
      exp_cnt = '0;
      rst       = 1'b1;
      req_valid = '0;
      req_in1   = '0;
      req_in2   = '0;
      res_ready = 1'b0;

      vecs[0] = '{0, 8'hFF, 8'hFF, 16'hFE01};
      vecs[1] = '{1, 8'h00, 8'hAB, 16'h0000};
      vecs[2] = '{2, 8'h80, 8'h02, 16'h0100};
      vecs[3] = '{3, 8'h01, 8'hFF, 16'h00FF};
      vecs[4] = '{1, 8'h12, 8'h34, 16'h03A8};
      vecs[5] = '{2, 8'hAB, 8'hCD, 16'h88EF};

      // reset state
      tick();
      tick();
      @(negedge clk);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_out", 32'(res_out), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_op_count", 32'(op_count), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      tick();
      rst = 1'b0;

      // single-request vectors, including edge operands
      foreach (vecs[k]) run_one(vecs[k]);

      // backpressure: result held while res_ready low, req1 waits
      res_ready = 1'b0;
      req_valid = 4'b0001;
      set_ops(0, 8'h07, 8'h09);
      @(negedge clk);
      check("bp_grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0010;
      set_ops(1, 8'h05, 8'h06);
      @(negedge clk);
      check("bp_calc_noready", 32'(req_ready), 32'h0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
      @(negedge clk);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_prod", 32'(res_out), 32'h3F);
      for (int c = 0; c < 5; c++) begin
         tick();
         @(negedge clk);
         check("bp_hold_valid", 32'(res_valid), 32'd1);
         check("bp_hold_out", 32'(res_out), 32'h3F);
         check("bp_hold_id", 32'(res_id), 32'd0);
         check("bp_hold_noready", 32'(req_ready), 32'h0);
      end
      tick();
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_regrant1", 32'(req_ready), 32'h2);
      tick();
      exp_cnt   = exp_cnt + 16'd1;
      req_valid = '0;
      @(negedge clk);
      check("bp_gap_valid", 32'(res_valid), 32'd0);
      tick();
      @(negedge clk);
      check("bp_prod1", 32'(res_out), 32'h1E);
      check("bp_id1", 32'(res_id), 32'd1);
      tick();
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      check("bp_opcount", 32'(op_count), 32'(exp_cnt));

      // strict rotation with all requesters valid
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) set_ops(i, 8'(i + 1), 8'h10);
      req_valid = '1;
      res_ready = 1'b1;
      ngr  = 0;
      nres = 0;
      last = 0;
      for (int c = 0; c < 40 && nres < 4; c++) begin
         @(negedge clk);
         gmask = req_ready;
         gid   = 0;
         if (gmask != 0) begin
            for (int i = 0; i < NUM_REQ; i++) if (gmask[i]) gid = i;
            check("rot_order", 32'(gid), 32'(ngr));
            if (ngr > 0) check("rot_gap", 32'(c - last), 32'd2);
            last = c;
            ngr++;
         end
         if (res_valid) begin
            check("rot_prod", 32'(res_out), 32'((int'(res_id) + 1) * 16));
            nres++;
         end
         tick();
         if (gmask != 0) req_valid[gid] = 1'b0;
      end
      check("rot_results", 32'(nres), 32'd4);
      exp_cnt = exp_cnt + 16'(nres);
      tick();
      @(negedge clk);
      check("rot_opcount", 32'(op_count), 32'(exp_cnt));

      // reset while CALC with a pending request
      tick();
      req_valid = 4'b0100;
      set_ops(2, 8'h0B, 8'h0C);
      @(negedge clk);
      check("rstc_grant", 32'(req_ready), 32'h4);
      tick();
      rst       = 1'b1;
      req_valid = 4'b1100;
      set_ops(3, 8'h02, 8'h03);
      @(negedge clk);
      check("rstc_calc_noready", 32'(req_ready), 32'h0);
      tick();
      rst     = 1'b0;
      exp_cnt = '0;
      @(negedge clk);
      check("rstc_valid", 32'(res_valid), 32'd0);
      check("rstc_busy", 32'(busy), 32'd0);
      check("rstc_opcount", 32'(op_count), 32'd0);
      check("rstc_ptr0_grant2", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      check("rstc_prod", 32'(res_out), 32'h84);
      check("rstc_id", 32'(res_id), 32'd2);
      tick();
      exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      check("rstc_opcount1", 32'(op_count), 32'(exp_cnt));

      // randomized traffic
      do_reset();
      pend = 1'b0;
      nx   = 0;
      ngr  = 0;
      for (int i = 0; i < NUM_REQ; i++) wt[i] = 0;
      for (int c = 0; c < 30000 && ngr < 2000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
               req_valid[i] = 1'b1;
               set_ops(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
         end
         res_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         observe_result();
         gmask = req_ready;
         gid   = 0;
         if (gmask != 0) begin
            for (int i = 0; i < NUM_REQ; i++) if (gmask[i]) gid = i;
            check("rnd_onehot", 32'($countones(gmask)), 32'd1);
            check("rnd_grant_valid", 32'(req_valid[gid]), 32'd1);
            check("rnd_starve", 32'(wt[gid] <= NUM_REQ - 1), 32'd1);
            wt[gid] = 0;
            for (int j = 0; j < NUM_REQ; j++) if (j != gid && req_valid[j]) wt[j]++;
            exp_p  = {8'b0, req_in1[8*gid +: 8]} * {8'b0, req_in2[8*gid +: 8]};
            exp_id = ID_W'(gid);
            pend   = 1'b1;
            ngr++;
         end
         tick();
         if (gmask != 0) req_valid[gid] = 1'b0;
      end
      check("rnd_grants", 32'(ngr), 32'd2000);
      req_valid = '0;
      res_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         observe_result();
         tick();
      end
      @(negedge clk);
      check("rnd_drained", 32'(pend), 32'd0);
      check("rnd_opcount", 32'(op_count), 32'(16'(nx)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
